// File: rtl/sc_level_timer_pkg.sv
// Shared constants and FSM encoding for the level timer.
package sc_level_timer_pkg;

   localparam int unsigned TimerWidth = 32;
   localparam int unsigned LevelWidth = 8;
   localparam int unsigned LevelMax   = 59;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArm  = 2'd1,
      StRun  = 2'd2,
      StDone = 2'd3
   } state_e;

endpackage

// File: rtl/sc_level_timer_downcounter.sv
// Reloadable down-counter; load has priority over enable, expired flags count==1 while enabled.
module sc_level_timer_downcounter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [Width-1:0] load_value,
   output logic             expired
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (enable) begin
         count_q <= count_q - Width'(1);
      end
   end

   assign expired = enable && (count_q == Width'(1));

endmodule

// File: rtl/sc_level_timer.sv
// Level timer: after START and a period LOAD, ticks every period and counts levels up to LEVEL_MAX.
module sc_level_timer
   import sc_level_timer_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH = TimerWidth,
   parameter int unsigned LEVEL_MAX   = LevelMax
) (
   input  logic                   SC_LEVEL_TIMER_CLOCK_50,
   input  logic                   SC_LEVEL_TIMER_RESET_InHigh,
   input  logic                   SC_LEVEL_TIMER_START_InLow,
   input  logic                   SC_LEVEL_TIMER_LOAD_InHigh,
   input  logic [TIMER_WIDTH-1:0] SC_LEVEL_TIMER_TIMER_CTE,
   output logic                   SC_LEVEL_TIMER_TICK_OutHigh,
   output logic [LevelWidth-1:0]  SC_LEVEL_TIMER_LEVEL,
   output logic                   SC_LEVEL_TIMER_RUNNING_OutHigh,
   output logic                   SC_LEVEL_TIMER_DONE_OutHigh
);

   localparam logic [LevelWidth-1:0] LevelTop  = LevelWidth'(LEVEL_MAX);
   localparam logic [LevelWidth-1:0] LevelLast = LevelWidth'(LEVEL_MAX - 1);

   state_e                  state_q;
   logic [TIMER_WIDTH-1:0]  period_q;
   logic [LevelWidth-1:0]   level_q;
   logic                    tick_q;
   logic                    running_q;
   logic                    done_q;

   logic [TIMER_WIDTH-1:0]  cte_eff;
   logic [TIMER_WIDTH-1:0]  cnt_value;
   logic                    cnt_load;
   logic                    cnt_enable;
   logic                    expired;

   // A zero period behaves as one so RUN ticks every cycle instead of stalling.
   always_comb begin
      cte_eff    = (SC_LEVEL_TIMER_TIMER_CTE == '0) ? TIMER_WIDTH'(1) : SC_LEVEL_TIMER_TIMER_CTE;
      cnt_enable = (state_q == StRun);
      cnt_load   = ((state_q == StArm) && SC_LEVEL_TIMER_LOAD_InHigh) || expired;
      cnt_value  = SC_LEVEL_TIMER_LOAD_InHigh ? cte_eff : period_q;
   end

   sc_level_timer_downcounter #(
      .Width (TIMER_WIDTH)
   ) u_downcounter (
      .clk        (SC_LEVEL_TIMER_CLOCK_50),
      .rst        (SC_LEVEL_TIMER_RESET_InHigh),
      .load       (cnt_load),
      .enable     (cnt_enable),
      .load_value (cnt_value),
      .expired    (expired)
   );

   always_ff @(posedge SC_LEVEL_TIMER_CLOCK_50 or posedge SC_LEVEL_TIMER_RESET_InHigh) begin
      if (SC_LEVEL_TIMER_RESET_InHigh) begin
         state_q   <= StIdle;
         period_q  <= '0;
         level_q   <= '0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!SC_LEVEL_TIMER_START_InLow) state_q <= StArm;
            end
            StArm: begin
               if (SC_LEVEL_TIMER_LOAD_InHigh) begin
                  period_q  <= cte_eff;
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end
            end
            StRun: begin
               if (SC_LEVEL_TIMER_LOAD_InHigh) period_q <= cte_eff;
               if (expired) begin
                  tick_q <= 1'b1;
                  if (level_q >= LevelLast) begin
                     level_q   <= LevelTop;
                     state_q   <= StDone;
                     running_q <= 1'b0;
                     done_q    <= 1'b1;
                  end else begin
                     level_q <= level_q + LevelWidth'(1);
                  end
               end
            end
            StDone: begin
               if (!SC_LEVEL_TIMER_START_InLow) begin
                  state_q <= StIdle;
                  level_q <= '0;
                  done_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign SC_LEVEL_TIMER_TICK_OutHigh    = tick_q;
   assign SC_LEVEL_TIMER_LEVEL           = level_q;
   assign SC_LEVEL_TIMER_RUNNING_OutHigh = running_q;
   assign SC_LEVEL_TIMER_DONE_OutHigh    = done_q;

endmodule

// File: tb/tb_sc_level_timer.sv
// Directed bench for sc_level_timer; expected outputs queued at drive time, checked after the edge.
module tb_sc_level_timer;

   typedef struct packed {
      logic       tick;
      logic [7:0] level;
      logic       running;
      logic       done;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_n;
   logic        load;
   logic [31:0] cte;
   logic        tick;
   logic [7:0]  level;
   logic        running;
   logic        done;

   int tests = 0;
   int fails = 0;
   obs_t  exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   sc_level_timer dut (
      .SC_LEVEL_TIMER_CLOCK_50        (clk),
      .SC_LEVEL_TIMER_RESET_InHigh    (rst),
      .SC_LEVEL_TIMER_START_InLow     (start_n),
      .SC_LEVEL_TIMER_LOAD_InHigh     (load),
      .SC_LEVEL_TIMER_TIMER_CTE       (cte),
      .SC_LEVEL_TIMER_TICK_OutHigh    (tick),
      .SC_LEVEL_TIMER_LEVEL           (level),
      .SC_LEVEL_TIMER_RUNNING_OutHigh (running),
      .SC_LEVEL_TIMER_DONE_OutHigh    (done)
   );

   function automatic obs_t mk(input logic t, input int lv, input logic r, input logic d);
      obs_t o;
      o.tick    = t;
      o.level   = 8'(lv);
      o.running = r;
      o.done    = d;
      return o;
   endfunction

   task automatic check_now(input string tag, input obs_t e);
      obs_t got;
      got = {tick, level, running, done};
      tests++;
      assert (got === e) else begin
         fails++;
         $error("FAIL %s: observed tick=%b level=%0d run=%b done=%b, expected tick=%b level=%0d run=%b done=%b",
                tag, got.tick, got.level, got.running, got.done, e.tick, e.level, e.running, e.done);
      end
   endtask

   // Inputs are driven at the falling edge; the queued expectation is checked one cycle later.
   task automatic cycle(input logic s, input logic l, input logic [31:0] c, input obs_t e,
                        input string tag);
      start_n = s;
      load    = l;
      cte     = c;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      @(negedge clk);
      check_now(tag_q.pop_front(), exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_now("reset_async", mk(0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      check_now("reset_held", mk(0, 0, 0, 0));
      rst = 1'b0;
   endtask

   initial begin
      int  lvl;
      logic t;
      rst     = 1'b0;
      start_n = 1'b1;
      load    = 1'b0;
      cte     = '0;
      @(negedge clk);

      // Scenario: period 3, START pulses in RUN are ignored.
      do_reset();
      cycle(1, 0, 0, mk(0, 0, 0, 0), "idle_after_reset");
      cycle(1, 1, 9, mk(0, 0, 0, 0), "idle_load_ignored");
      cycle(0, 0, 0, mk(0, 0, 0, 0), "start_to_arm");
      cycle(1, 1, 3, mk(0, 0, 1, 0), "arm_load3");
      for (int k = 1; k <= 9; k++) begin
         cycle((k == 2 || k == 4) ? 1'b0 : 1'b1, 0, 0,
               mk((k % 3) == 0, k / 3, 1, 0), $sformatf("p3_k%0d", k));
      end

      // Scenario: P=5, reload with 2 before expiry, then 4 exactly at an expiry.
      do_reset();
      cycle(0, 0, 0, mk(0, 0, 0, 0), "start_b");
      cycle(1, 1, 5, mk(0, 0, 1, 0), "arm_load5");
      lvl = 0;
      for (int k = 1; k <= 20; k++) begin
         t = (k == 5 || k == 7 || k == 9 || k == 11 || k == 15 || k == 19);
         if (t) lvl++;
         cycle(1, (k == 3 || k == 11), (k == 3) ? 32'd2 : 32'd4,
               mk(t, lvl, 1, 0), $sformatf("reload_k%0d", k));
      end

      // Scenario: zero period ticks every cycle and saturates at the terminal level.
      do_reset();
      cycle(0, 0, 0, mk(0, 0, 0, 0), "start_c");
      cycle(1, 1, 0, mk(0, 0, 1, 0), "arm_load0");
      for (int k = 1; k <= 59; k++) begin
         cycle(1, 0, 0, mk(1, k, k < 59, k == 59), $sformatf("p0_k%0d", k));
      end
      for (int k = 60; k <= 63; k++) begin
         cycle(1, (k == 61), 32'd5, mk(0, 59, 0, 1), $sformatf("done_hold_k%0d", k));
      end
      cycle(0, 0, 0, mk(0, 0, 0, 0), "done_to_idle");
      cycle(1, 1, 2, mk(0, 0, 0, 0), "idle_again_load_ignored");

      // Scenario: asynchronous reset between edges mid-RUN.
      cycle(0, 0, 0, mk(0, 0, 0, 0), "start_d");
      cycle(1, 1, 2, mk(0, 0, 1, 0), "arm_load2");
      cycle(1, 0, 0, mk(0, 0, 1, 0), "p2_k1");
      cycle(1, 0, 0, mk(1, 1, 1, 0), "p2_k2");
      cycle(1, 0, 0, mk(0, 1, 1, 0), "p2_k3");
      #2;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(1, k[0], 32'd1, mk(0, 0, 0, 0), $sformatf("post_reset_idle_%0d", k));
      end
      cycle(0, 0, 0, mk(0, 0, 0, 0), "start_e");
      cycle(1, 1, 2, mk(0, 0, 1, 0), "arm_load2_e");
      cycle(1, 0, 0, mk(0, 0, 1, 0), "p2e_k1");
      cycle(1, 0, 0, mk(1, 1, 1, 0), "p2e_k2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
